// File: rtl/unipolar_rz_pkg.sv
// Shared types and sizing helpers for the unipolar return-to-zero encoder.
// No logic; the lane counter width is derived from the largest timing parameter.
package unipolar_rz_pkg;

  typedef enum logic [1:0] {RZ_IDLE, RZ_HIGH, RZ_LOW, RZ_GAP} rz_state_t;

  function automatic int rz_counter_width(input int zh, input int zl, input int oh,
                                          input int ol, input int rc);
    int m;
    m = zh;
    if (zl > m) m = zl;
    if (oh > m) m = oh;
    if (ol > m) m = ol;
    if (rc > m) m = rc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/unipolar_rz_multi_if.sv
// Host word port: a single valid/ready stream with a channel select.
// in_ready is driven by the slave and never depends on in_valid.
// Backpressure: in_ready low holds the word at the host.
interface unipolar_rz_multi_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 24
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [CH_W-1:0]       in_channel;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_channel, output in_data, input in_ready);
  modport slave  (input in_valid, input in_channel, input in_data, output in_ready);
endinterface

// File: rtl/fifo.sv
// Generic show-ahead FIFO: rd_dat is valid whenever rd_vld is high.
// Latency: a write is visible on rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy drops when full; simultaneous write and pop both happen.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign wr_rdy = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
  assign rd_vld = (wr_ptr != rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_vld && wr_rdy) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld && wr_rdy) wr_ptr <= wr_ptr + 1'b1;
      if (rd_vld && rd_rdy) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/unipolar_rz_lane.sv
// One RZ lane: word FIFO plus IDLE/HIGH/LOW/GAP bit-timing FSM (UNIPOLAR_RZ_INVERT_EN adds polarity).
// Latency: word written into an empty idle lane drives line high one cycle later.
// Backpressure: wr_rdy follows FIFO space; words arriving during GAP wait for IDLE.
module unipolar_rz_lane
  import unipolar_rz_pkg::*;
#(
  parameter int DATA_WIDTH       = 24,
  parameter int FIFO_DEPTH       = 4,
  parameter int MSB_FIRST        = 1,
  parameter int ZERO_HIGH_CYCLES = 20,
  parameter int ZERO_LOW_CYCLES  = 42,
  parameter int ONE_HIGH_CYCLES  = 40,
  parameter int ONE_LOW_CYCLES   = 22,
  parameter int RESET_CYCLES     = 2600
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [DATA_WIDTH-1:0] wr_dat,
`ifdef UNIPOLAR_RZ_INVERT_EN
  input  logic                  invert,
`endif
  output logic                  line,
  output logic                  busy
);
  localparam int CW = rz_counter_width(ZERO_HIGH_CYCLES, ZERO_LOW_CYCLES, ONE_HIGH_CYCLES,
                                       ONE_LOW_CYCLES, RESET_CYCLES);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  rz_state_t             state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [IW-1:0]         bit_idx;
  logic                  line_q;
  logic                  f_vld;
  logic [DATA_WIDTH-1:0] f_dat;
  logic                  pop;
  logic                  cur_bit, next_bit, first_bit, last_bit, cnt_zero, pol;
`ifdef UNIPOLAR_RZ_INVERT_EN
  logic                  inv_q;
`endif

  function automatic logic [CW-1:0] high_cnt(input logic b);
    return b ? CW'(ONE_HIGH_CYCLES - 1) : CW'(ZERO_HIGH_CYCLES - 1);
  endfunction

  function automatic logic [CW-1:0] low_cnt(input logic b);
    return b ? CW'(ONE_LOW_CYCLES - 1) : CW'(ZERO_LOW_CYCLES - 1);
  endfunction

  fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .wr_vld (wr_vld),
    .wr_rdy (wr_rdy),
    .wr_dat (wr_dat),
    .rd_vld (f_vld),
    .rd_rdy (pop),
    .rd_dat (f_dat)
  );

  always_comb begin
    if (MSB_FIRST != 0) begin
      sh_next   = shreg << 1;
      cur_bit   = shreg[DATA_WIDTH-1];
      next_bit  = sh_next[DATA_WIDTH-1];
      first_bit = f_dat[DATA_WIDTH-1];
    end else begin
      sh_next   = shreg >> 1;
      cur_bit   = shreg[0];
      next_bit  = sh_next[0];
      first_bit = f_dat[0];
    end
  end

  assign cnt_zero = (cnt == '0);
  assign last_bit = (bit_idx == IW'(DATA_WIDTH - 1));
  // Back-to-back words: the next pop happens in the same cycle the last bit ends.
  assign pop      = f_vld && ((state == RZ_IDLE) || (state == RZ_LOW && cnt_zero && last_bit));
  assign busy     = (state != RZ_IDLE) || f_vld;
  assign line     = line_q;

`ifdef UNIPOLAR_RZ_INVERT_EN
  assign pol = (state == RZ_IDLE) ? invert : inv_q;
`else
  assign pol = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RZ_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      line_q  <= 1'b0;
`ifdef UNIPOLAR_RZ_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        RZ_IDLE: begin
          if (f_vld) begin
            shreg   <= f_dat;
            bit_idx <= '0;
            cnt     <= high_cnt(first_bit);
            line_q  <= ~pol;
            state   <= RZ_HIGH;
`ifdef UNIPOLAR_RZ_INVERT_EN
            inv_q   <= invert;
`endif
          end else begin
            line_q <= pol;
          end
        end
        RZ_HIGH: begin
          if (cnt_zero) begin
            cnt    <= low_cnt(cur_bit);
            line_q <= pol;
            state  <= RZ_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RZ_LOW: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!last_bit) begin
            shreg   <= sh_next;
            bit_idx <= bit_idx + 1'b1;
            cnt     <= high_cnt(next_bit);
            line_q  <= ~pol;
            state   <= RZ_HIGH;
          end else if (f_vld) begin
            shreg   <= f_dat;
            bit_idx <= '0;
            cnt     <= high_cnt(first_bit);
            line_q  <= ~pol;
            state   <= RZ_HIGH;
          end else begin
            cnt   <= CW'(RESET_CYCLES - 1);
            state <= RZ_GAP;
          end
        end
        default: begin
          if (cnt_zero) state <= RZ_IDLE;
          else          cnt   <= cnt - 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/unipolar_rz_multi.sv
// Multi-channel unipolar RZ encoder: one shared host port fans out to CHANNELS lanes (UNIPOLAR_RZ_INVERT_EN adds invert).
// Latency: accepted word appears on its line one cycle later when the lane is idle.
// Backpressure: in_ready reflects the selected lane's FIFO space; out-of-range channels never ready.
module unipolar_rz_multi
  import unipolar_rz_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int DATA_WIDTH       = 24,
  parameter int FIFO_DEPTH       = 4,
  parameter int MSB_FIRST        = 1,
  parameter int ZERO_HIGH_CYCLES = 20,
  parameter int ZERO_LOW_CYCLES  = 42,
  parameter int ONE_HIGH_CYCLES  = 40,
  parameter int ONE_LOW_CYCLES   = 22,
  parameter int RESET_CYCLES     = 2600
) (
  input  logic                clock,
  input  logic                reset_n,
  unipolar_rz_multi_if.slave  host,
`ifdef UNIPOLAR_RZ_INVERT_EN
  input  logic [CHANNELS-1:0] invert,
`endif
  output logic [CHANNELS-1:0] line,
  output logic [CHANNELS-1:0] busy
);
  logic [CHANNELS-1:0] wr_vld;
  logic [CHANNELS-1:0] wr_rdy;

  always_comb begin
    wr_vld        = '0;
    host.in_ready = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(host.in_channel) == c) begin
        wr_vld[c]     = host.in_valid;
        host.in_ready = wr_rdy[c];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    unipolar_rz_lane #(
      .DATA_WIDTH      (DATA_WIDTH),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .MSB_FIRST       (MSB_FIRST),
      .ZERO_HIGH_CYCLES(ZERO_HIGH_CYCLES),
      .ZERO_LOW_CYCLES (ZERO_LOW_CYCLES),
      .ONE_HIGH_CYCLES (ONE_HIGH_CYCLES),
      .ONE_LOW_CYCLES  (ONE_LOW_CYCLES),
      .RESET_CYCLES    (RESET_CYCLES)
    ) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .wr_vld (wr_vld[g]),
      .wr_rdy (wr_rdy[g]),
      .wr_dat (host.in_data),
`ifdef UNIPOLAR_RZ_INVERT_EN
      .invert (invert[g]),
`endif
      .line   (line[g]),
      .busy   (busy[g])
    );
  end
endmodule

// File: tb/tb_unipolar_rz_multi.sv
// Directed bench for unipolar_rz_multi: pulse widths, bit periods, gaps, backpressure, async reset.
// Expected pulse trains come from the words the bench itself wrote.
module tb_unipolar_rz_multi;
  localparam int CH = 2;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  unipolar_rz_multi_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();
  unipolar_rz_multi_if #(.CHANNELS(3),  .DATA_WIDTH(DW)) bus3 ();
  logic [CH-1:0] line, busy;
  logic [2:0]    line3, busy3;
`ifdef UNIPOLAR_RZ_INVERT_EN
  logic [CH-1:0] invert;
  logic [2:0]    invert3;
`endif

  unipolar_rz_multi #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .MSB_FIRST(1),
    .ZERO_HIGH_CYCLES(3), .ZERO_LOW_CYCLES(9), .ONE_HIGH_CYCLES(7), .ONE_LOW_CYCLES(5),
    .RESET_CYCLES(50)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .host(bus),
`ifdef UNIPOLAR_RZ_INVERT_EN
    .invert(invert),
`endif
    .line(line), .busy(busy)
  );

  unipolar_rz_multi #(
    .CHANNELS(3), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .MSB_FIRST(1),
    .ZERO_HIGH_CYCLES(3), .ZERO_LOW_CYCLES(9), .ONE_HIGH_CYCLES(7), .ONE_LOW_CYCLES(5),
    .RESET_CYCLES(50)
  ) u_dut3 (
    .clock(clock), .reset_n(reset_n), .host(bus3),
`ifdef UNIPOLAR_RZ_INVERT_EN
    .invert(invert3),
`endif
    .line(line3), .busy(busy3)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Line monitor: high pulse widths, rising-edge cycles and the last busy fall per lane.
  logic [CH-1:0] mon_inv = '0;
  int hi_q[CH][$];
  int rise_q[CH][$];
  int exp_bits[CH][$];
  int fall_busy[CH];

  initial begin
    logic [CH-1:0] pl, pb;
    int run[CH];
    logic v;
    pl = '0;
    pb = '0;
    for (int c = 0; c < CH; c++) begin run[c] = 0; fall_busy[c] = 0; end
    forever begin
      @(negedge clock);
      for (int c = 0; c < CH; c++) begin
        v = line[c] ^ mon_inv[c];
        if (v && !pl[c]) begin
          rise_q[c].push_back(cyc);
          run[c] = 1;
        end else if (v) begin
          run[c]++;
        end else if (pl[c]) begin
          hi_q[c].push_back(run[c]);
        end
        if (pb[c] && !busy[c]) fall_busy[c] = cyc;
        pl[c] = v;
        pb[c] = busy[c];
      end
    end
  end

  task automatic clear_mon();
    for (int c = 0; c < CH; c++) begin
      hi_q[c].delete();
      rise_q[c].delete();
      exp_bits[c].delete();
    end
  endtask

  task automatic send(input int c, input logic [DW-1:0] w, output bit ok);
    @(negedge clock);
    bus.in_valid   = 1'b1;
    bus.in_channel = c[0];
    bus.in_data    = w;
    #1 ok = bus.in_ready;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    if (ok) for (int i = DW - 1; i >= 0; i--) exp_bits[c].push_back(int'(w[i]));
  endtask

  task automatic wait_idle(input int c, input int budget, input string tag);
    int n;
    n = 0;
    while (busy[c] && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1 check({tag, " idle"}, int'(busy[c]), 0);
  endtask

  task automatic check_stream(input int c, input string tag, input bit contiguous);
    check({tag, " pulses"}, hi_q[c].size(), exp_bits[c].size());
    for (int i = 0; i < hi_q[c].size() && i < exp_bits[c].size(); i++)
      check($sformatf("%s hi[%0d]", tag, i), hi_q[c][i], (exp_bits[c][i] != 0) ? 7 : 3);
    if (contiguous)
      for (int i = 1; i < rise_q[c].size(); i++)
        check($sformatf("%s period[%0d]", tag, i), rise_q[c][i] - rise_q[c][i-1], 12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc, r, n;
    logic [DW-1:0] t2_w [6];
    t2_w = '{8'hFF, 8'h00, 8'h81, 8'h3C, 8'hC3, 8'h99};
    bus.in_valid = 1'b0; bus.in_channel = '0; bus.in_data = '0;
    bus3.in_valid = 1'b0; bus3.in_channel = '0; bus3.in_data = '0;
`ifdef UNIPOLAR_RZ_INVERT_EN
    invert = '0;
    invert3 = '0;
`endif
    repeat (3) @(posedge clock);
    #1 check("reset line", int'(line), 0);
    check("reset busy", int'(busy), 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1 check("ready ch0 empty", int'(bus.in_ready), 1);

    // Single word A5 on ch0: latency, pulse widths, periods, gap length to busy fall.
    clear_mon();
    send(0, 8'hA5, ok);
    check("t1 accepted", int'(ok), 1);
    check("t1 line before pop", int'(line[0]), 0);
    @(posedge clock);
    #1 check("t1 line after pop", int'(line[0]), 1);
    wait_idle(0, 2000, "t1");
    check_stream(0, "t1", 1'b1);
    if (rise_q[0].size() > 0)
      check("t1 last rise to busy fall", fall_busy[0] - rise_q[0][rise_q[0].size()-1], 62);
    else
      check("t1 rises seen", 0, 8);

    // Fill ch1: one word in the shifter plus four buffered, the next write is refused.
    clear_mon();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      send(1, t2_w[k], ok);
      if (ok) acc++;
    end
    check("t2 accepted count", acc, 5);
    check("t2 sixth write ready", int'(ok), 0);
    wait_idle(1, 3000, "t2");
    check_stream(1, "t2", 1'b1);
    if (rise_q[1].size() > 0)
      check("t2 gap after burst", fall_busy[1] - rise_q[1][rise_q[1].size()-1], 62);

    // Word written 20 cycles into the ch0 gap: the gap runs to completion.
    clear_mon();
    send(0, 8'h01, ok);
    n = 0;
    while (hi_q[0].size() < 8 && n < 500) begin @(negedge clock); n++; end
    check("t3 first word pulses", hi_q[0].size(), 8);
    r = (rise_q[0].size() >= 8) ? rise_q[0][7] : 0;
    n = 0;
    while (cyc < r + 30 && n < 500) begin @(negedge clock); n++; end
    send(0, 8'h80, ok);
    check("t3 accepted in gap", int'(ok), 1);
    wait_idle(0, 2000, "t3");
    check_stream(0, "t3", 1'b0);
    if (rise_q[0].size() >= 9)
      check("t3 rise after gap", rise_q[0][8] - r, 63);
    else
      check("t3 second word rises", rise_q[0].size(), 16);

    // Alternating writes to both lanes.
    clear_mon();
    send(0, 8'h5A, ok);
    send(1, 8'hE7, ok);
    send(0, 8'h0F, ok);
    send(1, 8'h12, ok);
    wait_idle(0, 2000, "t4 ch0");
    wait_idle(1, 2000, "t4 ch1");
    check_stream(0, "t4 ch0", 1'b1);
    check_stream(1, "t4 ch1", 1'b1);

    // Reset asserted mid-HIGH with words queued: line drops at once, queue is lost.
    clear_mon();
    send(0, 8'h80, ok);
    send(0, 8'hFF, ok);
    send(0, 8'hFF, ok);
    send(0, 8'hFF, ok);
    @(negedge clock);
    #1 check("t5 line high before reset", int'(line[0]), 1);
    #1 reset_n = 1'b0;
    #1 check("t5 line async", int'(line[0]), 0);
    check("t5 busy async", int'(busy[0]), 0);
    @(negedge clock) reset_n = 1'b1;
    clear_mon();
    repeat (300) @(negedge clock);
    #1 check("t5 no rises after reset", rise_q[0].size(), 0);
    check("t5 busy stays low", int'(busy[0]), 0);
    send(0, 8'h80, ok);
    wait_idle(0, 2000, "t5 new");
    check_stream(0, "t5 new", 1'b1);

    // Out-of-range channel select on a three-lane instance.
    @(negedge clock);
    bus3.in_valid = 1'b0; bus3.in_channel = 2'd2;
    #1 check("t6 ready ch2", int'(bus3.in_ready), 1);
    bus3.in_channel = 2'd3; bus3.in_valid = 1'b1; bus3.in_data = 8'hFF;
    #1 check("t6 ready ch3", int'(bus3.in_ready), 0);
    repeat (5) @(posedge clock);
    #1 check("t6 busy", int'(busy3), 0);
    check("t6 line", int'(line3), 0);
    bus3.in_valid = 1'b0;

`ifdef UNIPOLAR_RZ_INVERT_EN
    invert = 2'b01;
    repeat (3) @(negedge clock);
    #1 check("inv idle ch0", int'(line[0]), 1);
    check("inv idle ch1", int'(line[1]), 0);
    mon_inv = 2'b01;
    @(negedge clock);
    clear_mon();
    send(0, 8'hA5, ok);
    send(1, 8'h3C, ok);
    wait_idle(0, 2000, "inv ch0");
    wait_idle(1, 2000, "inv ch1");
    check_stream(0, "inv ch0", 1'b1);
    check_stream(1, "inv ch1", 1'b1);
    repeat (2) @(negedge clock);
    #1 check("inv idles high", int'(line[0]), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
